// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
//
// Frame controller and serializer for the UART transmitter. It accepts a
// parallel word and walks one frame: start bit, DATA_W data bits LSB-first,
// an optional parity bit, and a stop bit. It does not drive the line itself.
// Instead it steers a downstream 4:1 mux whose inputs are
//   i_1 = 0 (start), i_2 = ser_data, i_3 = par_bit, i_4 = 1 (stop/idle).
// Each bit period ends on an external one-cycle baud_tick strobe.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, the PARITY state and the parity
//                      generator are built, and par_en/par_typ are honoured.
//                      When undefined, par_bit is tied 0, par_en/par_typ are
//                      ignored, and DATA always proceeds to STOP.
//
// Parameters:
//   DATA_W      data bits per frame (5..9)
//   CNT_W       width of the bit counter
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   baud_tick   one-cycle strobe per bit period
//   data_valid  send request, accepted only while busy=0
//   p_data      parallel data word, captured at accept
//   par_en      1 = append a parity bit (captured at accept)
//   par_typ     0 = even parity, 1 = odd parity (captured at accept)
//   ser_data    current data bit (mux i_2)
//   par_bit     parity bit for the frame (mux i_3)
//   mux_sel     00 start, 01 data, 10 parity, 11 stop/idle
//   busy        high while a frame is in progress
//   done        one-cycle pulse when the stop bit period completes
// ---------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
    input  logic              par_en,
    input  logic              par_typ,
    output logic              ser_data,
    output logic              par_bit,
    output logic [1:0]        mux_sel,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    // Mux select codes for the downstream 4:1 line mux.
    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
`ifdef UART_TX_PARITY_EN
    localparam logic [1:0] SEL_PARITY = 2'b10;
`endif
    localparam logic [1:0] SEL_IDLE   = 2'b11;

    // Counter value of the final data bit of a frame.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ser_q,   ser_d;
    logic [1:0]        sel_q,   sel_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [CNT_W-1:0]  cnt_inc;

`ifdef UART_TX_PARITY_EN
    logic              par_q,    par_d;
    logic              par_en_q, par_en_d;
`else
    // Parity controls have no effect in this build; fold them into a
    // deliberately unused net so the ports stay in place.
    logic              unused_par_ctrl;
    assign unused_par_ctrl = par_en ^ par_typ;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    // mux_sel is registered from the next state so the line select changes on
    // the same edge as the state itself (no extra cycle of lag).
    function automatic logic [1:0] sel_of(input state_e s);
        case (s)
            S_START:  sel_of = SEL_START;
            S_DATA:   sel_of = SEL_DATA;
`ifdef UART_TX_PARITY_EN
            S_PARITY: sel_of = SEL_PARITY;
`endif
            default:  sel_of = SEL_IDLE;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first (hold), so
        // no path through the case leaves one unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ser_d    = ser_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
        par_en_d = par_en_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Accept does not wait for baud_tick; a tick on this same
                // edge is simply not seen by START.
                if (data_valid && !busy_q) begin
                    state_d  = S_START;
                    data_d   = p_data;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d    = (^p_data) ^ par_typ;
                    par_en_d = par_en;
`endif
                end
            end

            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    ser_d   = data_q[0];
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    if (cnt_q < LAST_BIT) begin
                        cnt_d = cnt_inc;
                        ser_d = data_q[cnt_inc];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        sel_d = sel_of(state_d);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            // NOTE: the data word is cleared on reset too, so nothing from an
            // aborted frame can leak onto ser_data before the next accept.
            data_q   <= '0;
            ser_q    <= 1'b0;
            sel_q    <= SEL_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the pre-edge values computed by the combinational block.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ser_q    <= ser_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
            par_en_q <= par_en_d;
`endif
        end
    end

    assign ser_data = ser_q;
    assign mux_sel  = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef UART_TX_PARITY_EN
    assign par_bit  = par_q;
`else
    assign par_bit  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fsm
//
// Self-checking bench for uart_tx_fsm. A behavioural model turns each
// accepted word into the list of line levels and mux selects expected per
// bit period. The bench then steps baud_tick and compares the DUT against
// that list, observing through the same 4:1 mux that sits downstream.
// Honours UART_TX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_tx_fsm;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_tick;
    logic          data_valid;
    logic [DW-1:0] p_data;
    logic          par_en;
    logic          par_typ;
    logic          ser_data;
    logic          par_bit;
    logic [1:0]    mux_sel;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected frame, one entry per bit period.
    logic [1:0] exp_sel[$];
    logic       exp_lvl[$];

    uart_tx_fsm #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    // Level seen on the serial line through the downstream mux.
    function automatic logic line_level();
        case (mux_sel)
            2'b00:   return 1'b0;
            2'b01:   return ser_data;
            2'b10:   return par_bit;
            default: return 1'b1;
        endcase
    endfunction

    // Even parity: total ones (data + parity) even. Odd: total ones odd.
    function automatic logic parity_of(input logic [DW-1:0] d, input logic odd);
        int ones;
        ones = $countones(d);
        if (odd) return (ones % 2) == 0;
        else     return (ones % 2) == 1;
    endfunction

    function automatic void build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_sel.delete();
        exp_lvl.delete();
        exp_sel.push_back(2'b00); exp_lvl.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_sel.push_back(2'b01); exp_lvl.push_back(d[i]);
        end
        if (HAS_PAR && pe) begin
            exp_sel.push_back(2'b10); exp_lvl.push_back(parity_of(d, pt));
        end
        exp_sel.push_back(2'b11); exp_lvl.push_back(1'b1);
    endfunction

    // {mux_sel, line, busy, done}
    function automatic logic [4:0] obs();
        return {mux_sel, line_level(), busy, done};
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus drivers (inputs change and outputs are sampled on negedge)
    // ---------------------------------------------------------------------
    task automatic accept(input string name, input logic [DW-1:0] d, input logic pe,
                          input logic pt, input logic tick, input logic keep);
        logic exp_par;
        exp_par    = HAS_PAR ? parity_of(d, pt) : 1'b0;
        data_valid = 1'b1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        baud_tick  = tick;
        @(negedge clk);
        baud_tick = 1'b0;
        if (!keep) data_valid = 1'b0;
        n_checks++;
        if ({obs(), par_bit} !== {2'b00, 1'b0, 1'b1, 1'b0, exp_par})
            $display("FAIL %s accept: {sel,line,busy,done,par}=%b expected %b",
                     name, {obs(), par_bit}, {2'b00, 1'b0, 1'b1, 1'b0, exp_par});
        else n_pass++;
    endtask

    // Runs a frame already accepted: holds each bit for 'gap' cycles then
    // ticks. With noise=1, data_valid/p_data/par_* are scrambled while busy.
    task automatic play_frame(input string name, input logic [DW-1:0] d, input logic pe,
                              input logic pt, input int gap, input logic noise);
        int busy_cycles;
        int n;
        build_frame(d, pe, pt);
        n = exp_sel.size();
        busy_cycles = 1;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (noise) begin
                    data_valid = 1'b1;
                    p_data     = DW'($urandom);
                    par_en     = 1'($urandom);
                    par_typ    = 1'($urandom);
                end
                @(negedge clk);
                if (busy) busy_cycles++;
            end
            n_checks++;
            if (obs() !== {exp_sel[k], exp_lvl[k], 2'b10})
                $display("FAIL %s hold bit %0d: {sel,line,busy,done}=%b expected %b",
                         name, k, obs(), {exp_sel[k], exp_lvl[k], 2'b10});
            else n_pass++;
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            if (busy) busy_cycles++;
            if (k + 1 < n) begin
                n_checks++;
                if (obs() !== {exp_sel[k+1], exp_lvl[k+1], 2'b10})
                    $display("FAIL %s enter bit %0d: {sel,line,busy,done}=%b expected %b",
                             name, k + 1, obs(), {exp_sel[k+1], exp_lvl[k+1], 2'b10});
                else n_pass++;
            end
        end
        n_checks++;
        if (obs() !== 5'b11_1_0_1)
            $display("FAIL %s done: {sel,line,busy,done}=%b expected %b", name, obs(), 5'b11_1_0_1);
        else n_pass++;
        n_checks++;
        if (busy_cycles !== n * (gap + 1))
            $display("FAIL %s busy length: cycles=%0d expected %0d", name, busy_cycles, n * (gap + 1));
        else n_pass++;
    endtask

    // Idle for 'cycles' cycles with random ticks; line must stay idle.
    task automatic idle_check(input string name, input int cycles);
        int bad;
        bad = 0;
        data_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            baud_tick = 1'($urandom);
            @(negedge clk);
            if (obs() !== 5'b11_1_0_0) bad++;
        end
        baud_tick = 1'b0;
        n_checks++;
        if (bad !== 0)
            $display("FAIL %s idle: non-idle cycles=%0d expected 0 (last {sel,line,busy,done}=%b)",
                     name, bad, obs());
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int saw_done;
        rst = 1'b1; baud_tick = 1'b0; data_valid = 1'b0;
        p_data = '0; par_en = 1'b0; par_typ = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({obs(), ser_data, par_bit} !== 7'b11_1_0_0_0_0)
            $display("FAIL reset initial: {sel,line,busy,done,ser,par}=%b expected %b",
                     {obs(), ser_data, par_bit}, 7'b11_1_0_0_0_0);
        else n_pass++;

        // Abort a frame part way through its data bits.
        accept("reset", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            baud_tick = 1'b1; @(negedge clk); baud_tick = 1'b0; @(negedge clk);
        end
        saw_done = 0;
        rst = 1'b1;
        @(negedge clk);
        if (done) saw_done++;
        n_checks++;
        if ({obs(), ser_data, par_bit} !== 7'b11_1_0_0_0_0)
            $display("FAIL reset mid-frame: {sel,line,busy,done,ser,par}=%b expected %b",
                     {obs(), ser_data, par_bit}, 7'b11_1_0_0_0_0);
        else n_pass++;
        @(negedge clk);
        if (done) saw_done++;
        rst = 1'b0;
        @(negedge clk);
        if (done) saw_done++;
        n_checks++;
        if (saw_done !== 0)
            $display("FAIL reset no-done: done pulses=%0d expected 0", saw_done);
        else n_pass++;
        idle_check("reset", 24);
    endtask

    task automatic test_basic();
        accept("basic", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        play_frame("basic", 8'hA5, 1'b0, 1'b0, 15, 1'b0);
        idle_check("basic", 4);
    endtask

    task automatic test_parity();
        accept("even_07", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        play_frame("even_07", 8'h07, 1'b1, 1'b0, 3, 1'b0);
        idle_check("even_07", 2);
        accept("odd_03", 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        play_frame("odd_03", 8'h03, 1'b1, 1'b1, 3, 1'b0);
        idle_check("odd_03", 2);
        accept("odd_07", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        play_frame("odd_07", 8'h07, 1'b1, 1'b1, 3, 1'b0);
        idle_check("odd_07", 2);
    endtask

    task automatic test_collision();
        accept("collision", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        p_data = 8'hFF;
        play_frame("collision", 8'h00, 1'b0, 1'b0, 4, 1'b1);
        idle_check("collision", 12);
    endtask

    task automatic test_back_to_back();
        accept("b2b_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        p_data = 8'hAA;
        play_frame("b2b_55", 8'h55, 1'b0, 1'b0, 2, 1'b0);
        // data_valid is still high on the done cycle: next edge starts AA.
        @(negedge clk);
        data_valid = 1'b0;
        n_checks++;
        if (obs() !== 5'b00_0_1_0)
            $display("FAIL b2b restart: {sel,line,busy,done}=%b expected %b", obs(), 5'b00_0_1_0);
        else n_pass++;
        play_frame("b2b_AA", 8'hAA, 1'b0, 1'b0, 2, 1'b0);
        idle_check("b2b", 3);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic          pe, pt, tk, nz;
        int            gap, idle;
        for (int f = 0; f < 10; f++) begin
            d    = DW'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            tk   = 1'($urandom);
            nz   = 1'($urandom);
            gap  = $urandom_range(1, 5);
            idle = $urandom_range(0, 3);
            accept("random", d, pe, pt, tk, 1'b0);
            play_frame("random", d, pe, pt, gap, nz);
            data_valid = 1'b0;
            if (idle > 0) idle_check("random", idle);
        end
        idle_check("random_end", 4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_collision();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
